// File: rtl/key_event_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_event_pkg
// Purpose  : Shared event codes, per-key state encoding and event word width
//            helper for the key event controller.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package key_event_pkg;

   // Event type codes; EV_NONE doubles as the "slot empty" marker.
   localparam logic [1:0] EV_NONE    = 2'b00;
   localparam logic [1:0] EV_PRESS   = 2'b01;
   localparam logic [1:0] EV_LONG    = 2'b10;
   localparam logic [1:0] EV_RELEASE = 2'b11;

   typedef enum logic [1:0] {
      KS_UP   = 2'd0,
      KS_DOWN = 2'd1,
      KS_LONG = 2'd2
   } key_state_t;

   // Event word = {type[1:0], key_idx}
   function automatic int ev_width(input int nkey);
      return 2 + $clog2(nkey);
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : key_event_ctrl_if
// Purpose  : Event stream bus between the key event controller (master) and
//            its consumer (slave).
// Signals  : ev_valid  - event available at FIFO head
//            ev_ready  - consumer accepts head event
//            ev_data   - {type[1:0], key_idx}
//            ev_ovf    - sticky event-dropped flag
//            clr_ovf   - clears ev_ovf
//            fifo_cnt  - FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
interface key_event_ctrl_if
   import key_event_pkg::*;
#(
   parameter int NKEY  = 4,
   parameter int DEPTH = 4
) ();

   localparam int C_EV_W  = ev_width(NKEY);
   localparam int C_CNT_W = $clog2(DEPTH) + 1;

   logic               ev_valid;
   logic               ev_ready;
   logic [C_EV_W-1:0]  ev_data;
   logic               ev_ovf;
   logic               clr_ovf;
   logic [C_CNT_W-1:0] fifo_cnt;

   modport master (
      output ev_valid, ev_data, ev_ovf, fifo_cnt,
      input  ev_ready, clr_ovf
   );

   modport slave (
      input  ev_valid, ev_data, ev_ovf, fifo_cnt,
      output ev_ready, clr_ovf
   );

endinterface
`default_nettype wire

// File: rtl/key_event_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : key_event_fifo
// Purpose  : Small first-word-fall-through FIFO with registered storage.
//            A push into a full FIFO is accepted when a pop happens in the
//            same cycle.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            push, push_data - write request and word
//            full            - FIFO holds DEPTH words
//            pop             - consumer takes head word (ignored when empty)
//            valid, data     - head word present / head word
//            count           - occupancy 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module key_event_fifo
   import key_event_pkg::*;
#(
   parameter int W     = 4,
   parameter int DEPTH = 4
) (
   input  wire logic                     clk,
   input  wire logic                     rst,
   input  wire logic                     push,
   input  wire logic [W-1:0]             push_data,
   output logic                          full,
   input  wire logic                     pop,
   output logic                          valid,
   output logic [W-1:0]                  data,
   output logic [$clog2(DEPTH):0]        count
);

   localparam int C_AW = $clog2(DEPTH);

   logic [W-1:0]    r_mem [DEPTH];
   logic [C_AW-1:0] r_wr;
   logic [C_AW-1:0] r_rd;
   logic [C_AW:0]   r_cnt;
   logic            w_push_ok;
   logic            w_pop_ok;

   assign valid     = (r_cnt != '0);
   assign full      = (r_cnt == (C_AW+1)'(DEPTH));
   assign data      = r_mem[r_rd];
   assign count     = r_cnt;
   assign w_pop_ok  = pop & valid;
   assign w_push_ok = push & (~full | w_pop_ok);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr] <= push_data;
            r_wr        <= r_wr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rd <= r_rd + 1'b1;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_event_ctrl
// Purpose  : Turns debounced key levels into an ordered PRESS / LONG /
//            RELEASE event stream. Each key has its own FSM and a one-deep
//            pending slot; a round-robin arbiter moves one slot per cycle
//            into the event FIFO.
// Ports    : clk  - system clock
//            rst  - synchronous reset, active-high
//            fs   - debounced key levels, 1 = pressed
//            bus  - event stream (master side of key_event_ctrl_if)
// Revision : 1.0 - initial release
// ============================================================================
module key_event_ctrl
   import key_event_pkg::*;
#(
   parameter int NKEY     = 4,
   parameter int LONG_CYC = 50_000_000,
   parameter int DEPTH    = 4
) (
   input  wire logic            clk,
   input  wire logic            rst,
   input  wire logic [NKEY-1:0] fs,
   key_event_ctrl_if.master     bus
);

   localparam int                C_IDX_W   = $clog2(NKEY);
   localparam int                C_EV_W    = ev_width(NKEY);
   localparam int                C_HC_W    = $clog2(LONG_CYC);
   localparam logic [C_HC_W-1:0] C_HC_LAST = C_HC_W'(LONG_CYC - 1);

   logic [NKEY-1:0]       r_fs_q;
   logic [NKEY-1:0]       w_rise;
   logic [NKEY-1:0]       w_fall;
   logic [NKEY-1:0][1:0]  w_slot;
   logic [NKEY-1:0]       w_occ;
   logic [NKEY-1:0]       w_drop;
   logic [NKEY-1:0]       w_gnt_oh;
   logic [C_IDX_W-1:0]    r_ptr;
   logic [C_IDX_W-1:0]    w_gnt_idx;
   logic [C_IDX_W-1:0]    w_cand;
   logic                  w_gnt_vld;
   logic                  w_can_push;
   logic                  w_fifo_full;
   logic                  w_fifo_valid;
   logic                  r_ovf;
   logic [C_EV_W-1:0]     w_push_data;

   assign w_rise = fs & ~r_fs_q;
   assign w_fall = ~fs & r_fs_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fs_q <= '0;
      end else begin
         r_fs_q <= fs;
      end
   end

   for (genvar gi = 0; gi < NKEY; gi++) begin : g_key
      key_state_t        r_state;
      logic [C_HC_W-1:0] r_hold;
      logic [1:0]        r_ev;     // event emitted this cycle, EV_NONE if none
      logic [1:0]        r_slot;   // pending event, EV_NONE when empty

      // Fall is tested before the hold limit so a release on the LONG cycle
      // yields only RELEASE.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_state <= KS_UP;
            r_hold  <= '0;
            r_ev    <= EV_NONE;
         end else begin
            r_ev <= EV_NONE;
            case (r_state)
               KS_UP: begin
                  if (w_rise[gi]) begin
                     r_state <= KS_DOWN;
                     r_hold  <= '0;
                     r_ev    <= EV_PRESS;
                  end
               end
               KS_DOWN: begin
                  if (w_fall[gi]) begin
                     r_state <= KS_UP;
                     r_ev    <= EV_RELEASE;
                  end else if (r_hold == C_HC_LAST) begin
                     r_state <= KS_LONG;
                     r_ev    <= EV_LONG;
                  end else if (fs[gi]) begin
                     r_hold <= r_hold + 1'b1;
                  end
               end
               KS_LONG: begin
                  if (w_fall[gi]) begin
                     r_state <= KS_UP;
                     r_ev    <= EV_RELEASE;
                  end
               end
               default: r_state <= KS_UP;
            endcase
         end
      end

      // A granted slot is emptied at this edge, so it may take a new event.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_slot <= EV_NONE;
         end else if ((r_ev != EV_NONE) && ((r_slot == EV_NONE) || w_gnt_oh[gi])) begin
            r_slot <= r_ev;
         end else if (w_gnt_oh[gi]) begin
            r_slot <= EV_NONE;
         end
      end

      assign w_slot[gi] = r_slot;
      assign w_occ[gi]  = (r_slot != EV_NONE);
      assign w_drop[gi] = (r_ev != EV_NONE) && (r_slot != EV_NONE) && !w_gnt_oh[gi];
   end

   // The FIFO can take a word when not full, or when its head leaves now.
   assign w_can_push = ~w_fifo_full | (w_fifo_valid & bus.ev_ready);

   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      w_cand    = '0;
      w_gnt_oh  = '0;
      for (int i = 0; i < NKEY; i++) begin
         w_cand = C_IDX_W'((int'(r_ptr) + i) % NKEY);
         if (!w_gnt_vld && w_occ[w_cand] && w_can_push) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = w_cand;
         end
      end
      if (w_gnt_vld) begin
         w_gnt_oh[w_gnt_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_gnt_vld) begin
            r_ptr <= C_IDX_W'((int'(w_gnt_idx) + 1) % NKEY);
         end
         if (|w_drop) begin
            r_ovf <= 1'b1;
         end else if (bus.clr_ovf) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign w_push_data = {w_slot[w_gnt_idx], w_gnt_idx};

   key_event_fifo #(
      .W     (C_EV_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_gnt_vld),
      .push_data (w_push_data),
      .full      (w_fifo_full),
      .pop       (bus.ev_ready),
      .valid     (w_fifo_valid),
      .data      (bus.ev_data),
      .count     (bus.fifo_cnt)
   );

   assign bus.ev_valid = w_fifo_valid;
   assign bus.ev_ovf   = r_ovf;

endmodule
`default_nettype wire
